// File: rtl/mulpop_pkg.sv
// Shared types and constants for the round-robin multiply/popcount arbiter.
package mulpop_pkg;

  typedef enum logic [1:0] {IDLE, MULT, POP, RESP} state_t;

  localparam int AW          = 24;
  localparam int PW          = 48;
  localparam int RW          = 32;
  localparam int ONES_W      = 6;
  localparam int MULT_CYCLES = 24;

  function automatic logic [ONES_W-1:0] popcount32(input logic [RW-1:0] x);
    logic [ONES_W-1:0] n;
    n = '0;
    for (int i = 0; i < RW; i++) begin
      n = n + ONES_W'(x[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/mulpop_arbiter_if.sv
// Requester and response channels of the multiply/popcount arbiter.
interface mulpop_arbiter_if #(parameter int NREQ = 4);
  import mulpop_pkg::*;

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_a;
  logic [NREQ*AW-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [RW-1:0]      rsp_w;
  logic [ONES_W-1:0]  rsp_ones;
  logic               rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_w, rsp_ones, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_w, rsp_ones, rsp_ovf
  );

endinterface

// File: rtl/mulpop_engine.sv
// Fixed-latency 24x24 shift-add multiplier with popcount of the low product word.
module mulpop_engine
  import mulpop_pkg::*;
(
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  input  logic [AW-1:0]     a,
  input  logic [AW-1:0]     b,
  output logic              done,
  output logic [RW-1:0]     w,
  output logic [ONES_W-1:0] ones,
  output logic              ovf
);

  localparam logic [4:0] LAST_K = 5'(MULT_CYCLES - 1);

  logic [PW-1:0] a_q;
  logic [PW-1:0] acc;
  logic [AW-1:0] b_q;
  logic [4:0]    k;
  logic          active;

  // One partial product per cycle; all 24 bits are walked even for zero operands.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      k      <= '0;
      active <= 1'b0;
    end else if (start) begin
      a_q    <= {{(PW-AW){1'b0}}, a};
      b_q    <= b;
      acc    <= '0;
      k      <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (b_q[k]) begin
        acc <= acc + (a_q << k);
      end
      if (k == LAST_K) begin
        active <= 1'b0;
      end else begin
        k <= k + 5'd1;
      end
    end
  end

  assign done = active && (k == LAST_K);
  assign w    = acc[RW-1:0];
  assign ones = popcount32(acc[RW-1:0]);
  assign ovf  = |acc[PW-1:RW];

endmodule

// File: rtl/mulpop_arbiter.sv
// Round-robin front end that shares one mulpop_engine among NREQ requesters.
module mulpop_arbiter
  import mulpop_pkg::*;
#(
  parameter int NREQ = 4
)(
  input  logic             clk,
  input  logic             n_reset,
  mulpop_arbiter_if.slave  bus,
  output logic             busy,
  output logic [15:0]      job_count
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state;
  state_t            state_nxt;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    grant;
  logic              grant_ok;
  logic              accept;
  logic              eng_done;
  logic [RW-1:0]     eng_w;
  logic [ONES_W-1:0] eng_ones;
  logic              eng_ovf;
  logic [IDW-1:0]    rsp_id_q;
  logic [RW-1:0]     rsp_w_q;
  logic [ONES_W-1:0] rsp_ones_q;
  logic              rsp_ovf_q;
  logic [15:0]       job_count_q;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    grant_ok = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!grant_ok && bus.req_valid[idx]) begin
        grant_ok = 1'b1;
        grant    = IDW'(idx);
      end
    end
  end

  assign accept        = (state == IDLE) && grant_ok && n_reset;
  assign bus.req_ready = accept ? (NREQ'(1) << grant) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = MULT;
      MULT:    if (eng_done)      state_nxt = POP;
      POP:                        state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  mulpop_engine u_engine (
    .clk     (clk),
    .n_reset (n_reset),
    .start   (accept),
    .a       (bus.req_a[int'(grant)*AW +: AW]),
    .b       (bus.req_b[int'(grant)*AW +: AW]),
    .done    (eng_done),
    .w       (eng_w),
    .ones    (eng_ones),
    .ovf     (eng_ovf)
  );

  // Response fields are only rewritten at grant (id) and POP (result), so they hold under backpressure.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state       <= IDLE;
      ptr         <= '0;
      rsp_id_q    <= '0;
      rsp_w_q     <= '0;
      rsp_ones_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      job_count_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rsp_id_q <= grant;
        ptr      <= (grant == IDW'(NREQ-1)) ? '0 : grant + IDW'(1);
      end
      if (state == POP) begin
        rsp_w_q    <= eng_w;
        rsp_ones_q <= eng_ones;
        rsp_ovf_q  <= eng_ovf;
      end
      if ((state == RESP) && bus.rsp_ready) begin
        job_count_q <= job_count_q + 16'd1;
      end
    end
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_w     = rsp_w_q;
  assign bus.rsp_ones  = rsp_ones_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign busy          = (state != IDLE);
  assign job_count     = job_count_q;

endmodule

// File: doc/mulpop_arbiter.md
Name: mulpop_arbiter

Overview:
- Round-robin scheduler sharing one 24x24 shift-add multiply plus popcount engine among NREQ requesters.
- Each requester presents two operands with a valid/ready handshake.
- The arbiter grants one requester, sequences the engine through multiply and popcount, and returns the low 32 product bits, their ones count, an overflow flag and the requester ID on a single response channel.
- Sits between the bus-mapped GPIO emulator registers and software-visible job sources.

Parameters:
- NREQ, 4: number of requesters (2..8).
- AW, 24: operand width.
- RW, 32: result word width returned to the requester.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- n_reset  input  1  synchronous, active-low reset.
- req_valid  input  NREQ  per-requester job request.
- req_ready  output  NREQ  one-hot grant/accept strobe.
- req_a  input  NREQ*AW  packed operand A, requester i at bits [i*AW +: AW].
- req_b  input  NREQ*AW  packed operand B, same packing.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  clog2(NREQ)  index of the requester that owns the response.
- rsp_w  output  RW  product[31:0].
- rsp_ones  output  6  number of ones in product[31:0] (0..32).
- rsp_ovf  output  1  product[47:32] non-zero.
- busy  output  1  high whenever state is not IDLE.
- job_count  output  16  completed-job counter.

Behaviour:
- Reset: sampled on the rising edge of clk while n_reset=0. All outputs go to 0, the round-robin pointer to 0 and the state to IDLE.
- Reset mid-job: the job is abandoned and no response is issued.
- States:
  - IDLE: if any req_valid, select a grant g by priority starting at the pointer and wrapping modulo NREQ. Assert req_ready[g] combinationally in that same cycle. Capture req_a/req_b slice g and rsp_id<=g. Set pointer<=(g+1) mod NREQ. Go to MULT. With no req_valid, stay in IDLE.
  - MULT: 24 cycles, bit counter k=0..23. The accumulator adds (A<<k) when B[k]=1. Product width is 48, with no truncation inside the engine. After k=23, go to POP.
  - POP: 1 cycle. Register rsp_w=product[31:0], rsp_ones=popcount(product[31:0]) and rsp_ovf=|product[47:32]. Go to RESP.
  - RESP: rsp_valid=1. On rsp_valid&rsp_ready, job_count<=job_count+1 (wraps 0xFFFF->0x0000) and go to IDLE.
- Latency: accept at cycle t. rsp_valid is first high at t+26 (MULT t+1..t+24, POP t+25).
- Throughput: the next grant is at the earliest in the cycle after the response handshake, i.e. one job per 27 cycles with rsp_ready tied high.
- req_ready is never asserted outside IDLE, and at most one bit is high in any cycle.
- A requester may drop req_valid before it is granted; only the grant cycle samples operands.
- Response outputs stay stable while rsp_valid=1 and rsp_ready=0.
- rsp_w, rsp_ones, rsp_ovf and rsp_id hold their last values after the handshake; they are qualified by rsp_valid only.
- Operand of 0 on either side: product 0, ones 0, ovf 0, still 24 MULT cycles (fixed latency).

Decomposition:
- Package mulpop_pkg:
  - state enum {IDLE, MULT, POP, RESP}
  - constants AW=24, PW=48, RW=32, ONES_W=6, MULT_CYCLES=24
- Sub-module mulpop_engine holds the shift-add accumulator, bit counter and popcount.
  - Inputs: start pulse, a, b.
  - Outputs: done pulse, w, ones, ovf.
- mulpop_arbiter keeps the grant logic, pointer, FSM, response register and job_count.

Test Plan:
- Single job: requester 0 sends a=3, b=5 at cycle t -> req_ready=0001 at t; rsp_valid at t+26 with id=0, w=0x0000000F, ones=4, ovf=0; job_count=1 after the handshake.
- Max operands: requester 2 sends a=b=0xFFFFFF -> id=2, w=0xFE000001, ones=8, ovf=1 (product 0xFFFFFE000001).
- Fairness: all four req_valid held high with rsp_ready=1 -> grants in order 0,1,2,3,0,1; consecutive grants exactly 27 cycles apart.
- Backpressure: rsp_ready held low 10 cycles after rsp_valid -> rsp_valid and all rsp_* outputs stable, req_ready=0, busy=1; handshake on the 11th cycle, then IDLE next cycle.
- Reset mid-MULT: n_reset=0 for one cycle at MULT k=10 -> next cycle all outputs 0 and state IDLE, no rsp_valid. A fresh job a=7, b=6 -> w=42, ones=3.
- Counter wrap: 65536 jobs with a=0 -> each w=0, ones=0, ovf=0; job_count returns to 0x0000.
